// File: rtl/mem_low_resp.sv
// Fixed-latency 64-bit backing memory behind the L2 low port: IDLE -> WAIT -> RESP.
// Optional snoop broadcast on request acceptance is built when MEM_SNOOP_BCAST_EN is defined.
module mem_low_resp #(
    parameter int LATENCY    = 2,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_low,
    input  logic        rw_low,
    input  logic [23:0] addr_low,
    input  logic [63:0] data_low_out,
    output logic [63:0] data_low_in,
    output logic        RDY_low,
    output logic        busy,
    output logic [2:0]  snoop_sig,
    output logic [23:0] addr_sp_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [63:0] mem [0:(2**DEPTH_LOG2)-1];

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  rw_q, rw_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [63:0]           wdata_q, wdata_d;
    logic                  rdy_q, rdy_d;
    logic [63:0]           rdata_q, rdata_d;
    logic                  mem_we;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdy_d   = 1'b0;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ce_low) begin
                    rw_d    = rw_low;
                    idx_d   = addr_low[DEPTH_LOG2:1];
                    wdata_d = data_low_out;
                    cnt_d   = CNT_INIT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    rdy_d   = 1'b1;
                    if (rw_q) begin
                        rdata_d = mem[idx_q];
                    end else begin
                        mem_we = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rw_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 64'd0;
            rdy_q   <= 1'b0;
            rdata_q <= 64'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdy_q   <= rdy_d;
            rdata_q <= rdata_d;
        end
    end

    // The array is not reset; reset only blocks a write-back that would commit at this edge.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign data_low_in = rdata_q;
    assign RDY_low     = rdy_q;
    assign busy        = (state_q != ST_IDLE);

`ifdef MEM_SNOOP_BCAST_EN
    logic [2:0]  snoop_q, snoop_d;
    logic [23:0] addr_sp_q, addr_sp_d;

    always_comb begin
        snoop_d   = 3'b000;
        addr_sp_d = addr_sp_q;
        if (state_q == ST_IDLE && ce_low) begin
            snoop_d   = rw_low ? 3'b001 : 3'b101;
            addr_sp_d = addr_low;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            snoop_q   <= 3'b000;
            addr_sp_q <= 24'd0;
        end else begin
            snoop_q   <= snoop_d;
            addr_sp_q <= addr_sp_d;
        end
    end

    assign snoop_sig   = snoop_q;
    assign addr_sp_out = addr_sp_q;
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_low[23:DEPTH_LOG2+1], addr_low[0]};
    assign snoop_sig   = 3'b000;
    assign addr_sp_out = 24'd0;
`endif

endmodule

// File: tb/tb_mem_low_resp.sv
// Bench for mem_low_resp: directed requests, expected responses queued with their due cycle.
// Snoop expectations follow MEM_SNOOP_BCAST_EN as defined for the build.
module tb_mem_low_resp;
    localparam int LATENCY    = 2;
    localparam int DEPTH_LOG2 = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce_low = 1'b0;
    logic        rw_low = 1'b0;
    logic [23:0] addr_low = 24'd0;
    logic [63:0] data_low_out = 64'd0;
    logic [63:0] data_low_in;
    logic        RDY_low;
    logic        busy;
    logic [2:0]  snoop_sig;
    logic [23:0] addr_sp_out;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [63:0] last_rd = 64'd0;
    logic [79:0] exp_q[$];
    logic [79:0] mon_e;

    mem_low_resp #(.LATENCY(LATENCY), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk(clk), .reset(reset), .ce_low(ce_low), .rw_low(rw_low),
        .addr_low(addr_low), .data_low_out(data_low_out), .data_low_in(data_low_in),
        .RDY_low(RDY_low), .busy(busy), .snoop_sig(snoop_sig), .addr_sp_out(addr_sp_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every RDY_low sample must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (RDY_low === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rdy: got RDY_low=1 expected 0 (cycle %0d)", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("rdy_cycle", 64'(cyc), 64'(mon_e[79:64]));
                check("data_low_in", data_low_in, mon_e[63:0]);
            end
        end
    end

    task automatic wait_idle();
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) return;
        end
        checks++;
        errors++;
        $display("FAIL rsp_timeout: got %0d pending expected 0", exp_q.size());
        exp_q.delete();
    endtask

    // rst_at: 0 none, 1 reset at first WAIT edge, 2 reset at the WAIT->RESP edge.
    task automatic req(input logic rw, input logic [23:0] a, input logic [63:0] d,
                       input logic [63:0] exp_rd, input bit hold, input bit scramble,
                       input int rst_at);
        logic [2:0]  exp_snoop;
        logic [23:0] exp_sp;
        @(negedge clk);
        reset = 1'b0;
        ce_low = 1'b1;
        rw_low = rw;
        addr_low = a;
        data_low_out = d;
        @(posedge clk);
        #1;
        if (rst_at == 0) begin
            if (rw) last_rd = exp_rd;
            exp_q.push_back({16'(cyc + LATENCY), last_rd});
        end
        check("busy_wait", 64'(busy), 64'd1);
`ifdef MEM_SNOOP_BCAST_EN
        exp_snoop = rw ? 3'b001 : 3'b101;
        exp_sp = a;
`else
        exp_snoop = 3'b000;
        exp_sp = 24'd0;
`endif
        check("snoop_accept", 64'(snoop_sig), 64'(exp_snoop));
        check("addr_sp_accept", 64'(addr_sp_out), 64'(exp_sp));
        if (!hold) ce_low = 1'b0;
        if (scramble) begin
            addr_low = ~a;
            data_low_out = ~d;
            rw_low = ~rw;
        end
        if (rst_at == 1) reset = 1'b1;
        @(posedge clk);
        #1;
        if (rst_at == 1) begin
            reset = 1'b0;
            exp_sp = 24'd0;
        end
        check("snoop_after", 64'(snoop_sig), 64'd0);
        check("addr_sp_hold", 64'(addr_sp_out), 64'(exp_sp));
        if (rst_at == 2) reset = 1'b1;
    endtask

    task automatic post_abort_checks();
        @(posedge clk);
        #1;
        check("abort_rdy", 64'(RDY_low), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_data", data_low_in, 64'd0);
        last_rd = 64'd0;
    endtask

    initial begin
        for (int i = 0; i < 2**DEPTH_LOG2; i++) dut.mem[i] = {8{8'(i)}};
        dut.mem[2] = 64'h3344556677889900;

        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", 64'(RDY_low), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_data", data_low_in, 64'd0);
        check("rst_snoop", 64'(snoop_sig), 64'd0);
        check("rst_addr_sp", 64'(addr_sp_out), 64'd0);

        // Read latency, first edge after reset release.
        req(1'b1, 24'hD00004, 64'd0, 64'h3344556677889900, 1'b0, 1'b0, 0);
        wait_idle();

        // Chained write-back then fill with ce_low held.
        req(1'b0, 24'hF50002, 64'h2b2b2b2b2b2b2b2b, 64'd0, 1'b1, 1'b0, 0);
        wait_idle();
        req(1'b1, 24'hF50002, 64'd0, 64'h2b2b2b2b2b2b2b2b, 1'b0, 1'b0, 0);
        wait_idle();

        // Inputs changed during WAIT are ignored.
        req(1'b0, 24'h000030, 64'hA5A5A5A5A5A5A5A5, 64'd0, 1'b0, 1'b1, 0);
        wait_idle();
        req(1'b1, 24'h000030, 64'd0, 64'hA5A5A5A5A5A5A5A5, 1'b0, 1'b0, 0);
        wait_idle();
        req(1'b1, 24'h000040, 64'd0, 64'h2020202020202020, 1'b0, 1'b0, 0);
        wait_idle();

        // Aliasing: index 0x02 through different upper bits and bit 0.
        req(1'b0, 24'h000204, 64'h0123456789ABCDEF, 64'd0, 1'b0, 1'b0, 0);
        wait_idle();
        req(1'b1, 24'hF00205, 64'd0, 64'h0123456789ABCDEF, 1'b0, 1'b0, 0);
        wait_idle();

        // Snoop broadcast for a write and a read.
        req(1'b0, 24'h348740, 64'h5555, 64'd0, 1'b0, 1'b0, 0);
        wait_idle();
        req(1'b1, 24'h348740, 64'd0, 64'h5555, 1'b0, 1'b0, 0);
        wait_idle();

        // Reset in WAIT aborts the write to index 0x10.
        req(1'b0, 24'h000020, 64'hFFFF, 64'd0, 1'b0, 1'b0, 1);
        post_abort_checks();
        repeat (4) @(negedge clk);
        req(1'b1, 24'h000020, 64'd0, 64'h1010101010101010, 1'b0, 1'b0, 0);
        wait_idle();

        // Reset on the WAIT->RESP edge, then a read on the first edge after release.
        req(1'b0, 24'h000022, 64'hBAD, 64'd0, 1'b0, 1'b0, 2);
        post_abort_checks();
        req(1'b1, 24'h000022, 64'd0, 64'h1111111111111111, 1'b0, 1'b0, 0);
        wait_idle();

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
